// File: rtl/glcd_pkg.sv
// Shared command bytes, panel geometry and sequencer states for the
// KS0108-style 128x64 refresh scheduler.
package glcd_pkg;

    localparam logic [7:0] CMD_DISP_ON    = 8'h3F;
    localparam logic [7:0] CMD_START_LINE = 8'hC0;
    localparam logic [7:0] CMD_SET_PAGE   = 8'hB8;
    localparam logic [7:0] CMD_SET_COL    = 8'h40;

    localparam int unsigned PAGES = 8;
    localparam int unsigned COLS  = 64;
    localparam int unsigned CHIPS = 2;

    typedef enum logic [3:0] {
        RST_HOLD,
        INIT_ON,
        INIT_LINE,
        IDLE,
        HOST_WR,
        HOST_BND,
        PAGE_WR,
        COL_WR,
        FETCH,
        CAPTURE,
        DATA_ISSUE,
        DATA_WR,
        FRAME_END
    } glcd_state_e;

    // Chip select pair {cs2, cs1} addressing a single controller.
    function automatic logic [1:0] chip_cs(input logic chip);
        return chip ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/glcd_bus_cycle.sv
// One LCD write: setup, E pulse, hold. done is asserted in the last hold
// cycle so the caller can chain the next write with no extra gap.
module glcd_bus_cycle #(
    parameter int unsigned T_SETUP = 4,
    parameter int unsigned T_PULSE = 24,
    parameter int unsigned T_HOLD  = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       rs,
    input  logic [1:0] cs,
    input  logic [7:0] data,
    output logic       done,
    output logic       lcd_e,
    output logic       lcd_rs,
    output logic       lcd_cs1,
    output logic       lcd_cs2,
    output logic [7:0] lcd_data
);

    localparam int unsigned TOTAL = T_SETUP + T_PULSE + T_HOLD;
    localparam int unsigned CW    = $clog2(TOTAL + 1);

    logic          active;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nx;
    logic          e_nx;

    assign done   = active && (cnt == CW'(TOTAL - 1));
    assign cnt_nx = cnt + CW'(1);
    assign e_nx   = (cnt_nx >= CW'(T_SETUP)) && (cnt_nx < CW'(T_SETUP + T_PULSE));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            active   <= 1'b0;
            cnt      <= '0;
            lcd_e    <= 1'b0;
            lcd_rs   <= 1'b0;
            lcd_cs1  <= 1'b0;
            lcd_cs2  <= 1'b0;
            lcd_data <= '0;
        end else if (start) begin
            active   <= 1'b1;
            cnt      <= '0;
            lcd_e    <= (T_SETUP == 0);
            lcd_rs   <= rs;
            lcd_cs1  <= cs[0];
            lcd_cs2  <= cs[1];
            lcd_data <= data;
        end else if (active) begin
            if (done) begin
                active <= 1'b0;
                cnt    <= '0;
                lcd_e  <= 1'b0;
            end else begin
                cnt   <= cnt_nx;
                lcd_e <= e_nx;
            end
        end
    end

endmodule

// File: rtl/glcd_refresh_scheduler.sv
// Power-up, init and full-screen refresh sequencer for a dual-controller
// 128x64 GLCD with a host command port. Optional macro: GLCD_INVERT_EN.
module glcd_refresh_scheduler
    import glcd_pkg::*;
#(
    parameter int unsigned T_SETUP     = 4,
    parameter int unsigned T_PULSE     = 24,
    parameter int unsigned T_HOLD      = 4,
    parameter int unsigned POWERUP_CYC = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       refresh_req,
    output logic       busy,
    output logic       frame_done,
    output logic       fb_rd,
    output logic [9:0] fb_addr,
    input  logic [7:0] fb_data,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_rs,
    input  logic [1:0] cmd_cs,
    input  logic [7:0] cmd_data,
`ifdef GLCD_INVERT_EN
    input  logic       invert,
`endif
    output logic       lcd_e,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_cs1,
    output logic       lcd_cs2,
    output logic       lcd_rst_n,
    output logic [7:0] lcd_data
);

    localparam int unsigned RW        = $clog2(POWERUP_CYC + 1);
    localparam logic [5:0]  COL_LAST  = 6'(COLS - 1);
    localparam logic [2:0]  PAGE_LAST = 3'(PAGES - 1);
    localparam logic        CHIP_LAST = 1'(CHIPS - 1);

    glcd_state_e   state_q, state_d;
    logic [RW-1:0] rst_cnt;
    logic          lcd_rst_q;
    logic          pend_q;
    logic          chip_q, chip_nx;
    logic [2:0]    page_q, page_nx;
    logic [5:0]    col_q;
    logic [7:0]    data_q, data_byte;
    logic          frame_last;

    logic          bus_start, bus_rs, bus_done;
    logic [1:0]    bus_cs;
    logic [7:0]    bus_data;
    logic          refresh_go, pos_adv, col_inc, cap;

`ifdef GLCD_INVERT_EN
    logic invert_q;
    assign data_byte = data_q ^ {8{invert_q}};
`else
    assign data_byte = data_q;
`endif

    assign frame_last = (chip_q == CHIP_LAST) && (page_q == PAGE_LAST) && (col_q == COL_LAST);
    // Chip is the inner loop: page0/chip0, page0/chip1, page1/chip0, ...
    assign chip_nx    = (chip_q == CHIP_LAST) ? 1'b0 : chip_q + 1'b1;
    assign page_nx    = (chip_q == CHIP_LAST) ? page_q + 3'd1 : page_q;

    assign busy      = (state_q != IDLE);
    assign fb_addr   = {chip_q, page_q, col_q};
    assign lcd_rw    = 1'b0;
    assign lcd_rst_n = lcd_rst_q;

    always_comb begin
        state_d    = state_q;
        bus_start  = 1'b0;
        bus_rs     = 1'b0;
        bus_cs     = 2'b00;
        bus_data   = '0;
        cmd_ready  = 1'b0;
        refresh_go = 1'b0;
        pos_adv    = 1'b0;
        col_inc    = 1'b0;
        cap        = 1'b0;
        fb_rd      = 1'b0;
        frame_done = 1'b0;
        case (state_q)
            RST_HOLD: if (rst_cnt == RW'(POWERUP_CYC - 1)) begin
                bus_start = 1'b1; bus_cs = 2'b11; bus_data = CMD_DISP_ON;
                state_d   = INIT_ON;
            end
            INIT_ON: if (bus_done) begin
                bus_start = 1'b1; bus_cs = 2'b11; bus_data = CMD_START_LINE;
                state_d   = INIT_LINE;
            end
            INIT_LINE: if (bus_done) state_d = IDLE;
            IDLE: if (cmd_valid) begin
                cmd_ready = 1'b1;
                bus_start = 1'b1; bus_rs = cmd_rs; bus_cs = cmd_cs; bus_data = cmd_data;
                state_d   = HOST_WR;
            end else if (pend_q) begin
                refresh_go = 1'b1;
                bus_start  = 1'b1; bus_cs = chip_cs(1'b0); bus_data = CMD_SET_PAGE;
                state_d    = PAGE_WR;
            end
            HOST_WR: if (bus_done) state_d = IDLE;
            HOST_BND: if (bus_done) begin
                bus_start = 1'b1; bus_cs = chip_cs(chip_q); bus_data = CMD_SET_PAGE | {5'b0, page_q};
                state_d   = PAGE_WR;
            end
            PAGE_WR: if (bus_done) begin
                bus_start = 1'b1; bus_cs = chip_cs(chip_q); bus_data = CMD_SET_COL;
                state_d   = COL_WR;
            end
            COL_WR: if (bus_done) state_d = FETCH;
            FETCH: begin
                fb_rd   = 1'b1;
                state_d = CAPTURE;
            end
            CAPTURE: begin
                cap     = 1'b1;
                state_d = DATA_ISSUE;
            end
            DATA_ISSUE: begin
                bus_start = 1'b1; bus_rs = 1'b1; bus_cs = chip_cs(chip_q); bus_data = data_byte;
                state_d   = DATA_WR;
            end
            // Page boundary: position advances now, so HOST_BND later reads the new page/chip.
            DATA_WR: if (bus_done) begin
                if (col_q != COL_LAST) begin
                    col_inc = 1'b1;
                    state_d = FETCH;
                end else if (frame_last) begin
                    state_d = FRAME_END;
                end else begin
                    pos_adv = 1'b1;
                    if (cmd_valid) begin
                        cmd_ready = 1'b1;
                        bus_start = 1'b1; bus_rs = cmd_rs; bus_cs = cmd_cs; bus_data = cmd_data;
                        state_d   = HOST_BND;
                    end else begin
                        bus_start = 1'b1; bus_cs = chip_cs(chip_nx); bus_data = CMD_SET_PAGE | {5'b0, page_nx};
                        state_d   = PAGE_WR;
                    end
                end
            end
            FRAME_END: begin
                frame_done = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = RST_HOLD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= RST_HOLD;
            rst_cnt   <= '0;
            lcd_rst_q <= 1'b0;
            pend_q    <= 1'b0;
            chip_q    <= 1'b0;
            page_q    <= '0;
            col_q     <= '0;
            data_q    <= '0;
`ifdef GLCD_INVERT_EN
            invert_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            if (state_q == RST_HOLD) rst_cnt <= rst_cnt + RW'(1);
            if (state_q == RST_HOLD && state_d != RST_HOLD) lcd_rst_q <= 1'b1;
            pend_q <= (pend_q & ~refresh_go) | refresh_req;
            if (refresh_go) begin
                chip_q <= 1'b0;
                page_q <= '0;
                col_q  <= '0;
            end else if (pos_adv) begin
                chip_q <= chip_nx;
                page_q <= page_nx;
                col_q  <= '0;
            end else if (col_inc) begin
                col_q <= col_q + 6'd1;
            end
            if (cap) data_q <= fb_data;
`ifdef GLCD_INVERT_EN
            if (refresh_go) invert_q <= invert;
`endif
        end
    end

    glcd_bus_cycle #(
        .T_SETUP(T_SETUP),
        .T_PULSE(T_PULSE),
        .T_HOLD (T_HOLD)
    ) u_bus (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (bus_start),
        .rs      (bus_rs),
        .cs      (bus_cs),
        .data    (bus_data),
        .done    (bus_done),
        .lcd_e   (lcd_e),
        .lcd_rs  (lcd_rs),
        .lcd_cs1 (lcd_cs1),
        .lcd_cs2 (lcd_cs2),
        .lcd_data(lcd_data)
    );

endmodule

// File: tb/tb_glcd_refresh_scheduler.sv
// Scoreboard bench: expected LCD writes are queued by the stimulus and
// popped by a monitor on every lcd_e rising edge.
module tb_glcd_refresh_scheduler;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       refresh_req;
    logic       busy, frame_done, fb_rd, cmd_ready;
    logic [9:0] fb_addr;
    logic [7:0] fb_data = 8'h00;
    logic       cmd_valid, cmd_rs;
    logic [1:0] cmd_cs;
    logic [7:0] cmd_data;
    logic       lcd_e, lcd_rs, lcd_rw, lcd_cs1, lcd_cs2, lcd_rst_n;
    logic [7:0] lcd_data;
`ifdef GLCD_INVERT_EN
    logic       invert = 1'b0;
`endif

    int n_chk = 0;
    int n_fail = 0;
    int wr_cnt = 0;
    int fd_cnt = 0;
    int rdy_cyc = 0;
    int e_len = 0;
    logic e_prev = 1'b0;
    logic [9:0] last_fetch = '0;
    logic [11:0] exp_q[$];

    always #5 clk = ~clk;

    glcd_refresh_scheduler #(.POWERUP_CYC(100)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .refresh_req(refresh_req),
        .busy       (busy),
        .frame_done (frame_done),
        .fb_rd      (fb_rd),
        .fb_addr    (fb_addr),
        .fb_data    (fb_data),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_rs     (cmd_rs),
        .cmd_cs     (cmd_cs),
        .cmd_data   (cmd_data),
`ifdef GLCD_INVERT_EN
        .invert     (invert),
`endif
        .lcd_e      (lcd_e),
        .lcd_rs     (lcd_rs),
        .lcd_rw     (lcd_rw),
        .lcd_cs1    (lcd_cs1),
        .lcd_cs2    (lcd_cs2),
        .lcd_rst_n  (lcd_rst_n),
        .lcd_data   (lcd_data)
    );

    // Framebuffer model: byte at address a holds a[7:0], one-cycle read latency.
    always @(posedge clk) if (fb_rd) fb_data <= fb_addr[7:0];

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [11:0] wr(input logic rs, input logic [1:0] cs, input logic [7:0] d);
        return {1'b0, rs, cs, d};
    endfunction

    task automatic push_frame(input int host_after, input logic [11:0] host_w);
        for (int p = 0; p < 8; p++) begin
            for (int c = 0; c < 2; c++) begin
                logic [1:0] cs;
                cs = (c == 0) ? 2'b01 : 2'b10;
                exp_q.push_back(wr(1'b0, cs, 8'hB8 | 8'(p)));
                exp_q.push_back(wr(1'b0, cs, 8'h40));
                for (int col = 0; col < 64; col++)
                    exp_q.push_back(wr(1'b1, cs, 8'((p % 4) * 64 + col)));
                if (p * 2 + c == host_after) exp_q.push_back(host_w);
            end
        end
    endtask

    task automatic check_powerup();
        int n;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!lcd_rst_n && n < 1000);
        chk("powerup_len", n, 100);
    endtask

    task automatic wait_idle(input int lim);
        int n;
        n = 0;
        while (busy && n < lim) begin
            @(negedge clk);
            n++;
        end
        chk("reach_idle", int'(busy), 0);
    endtask

    always @(negedge clk) begin
        if (frame_done) fd_cnt++;
        if (cmd_ready) rdy_cyc++;
        if (fb_rd) last_fetch = fb_addr;
        if (!rst_n) begin
            e_prev = 1'b0;
            e_len  = 0;
        end else begin
            if (lcd_e && !e_prev) begin
                wr_cnt++;
                e_len = 1;
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_write: actual 0x%0h, scoreboard empty",
                             {lcd_rw, lcd_rs, lcd_cs2, lcd_cs1, lcd_data});
                end else begin
                    chk("lcd_write", int'({lcd_rw, lcd_rs, lcd_cs2, lcd_cs1, lcd_data}),
                        int'(exp_q.pop_front()));
                end
            end else if (lcd_e) begin
                e_len++;
            end else if (e_prev) begin
                chk("e_pulse_len", e_len, 24);
            end
            e_prev = lcd_e;
        end
    end

    initial begin
        int n, w;
        rst_n = 1'b0; refresh_req = 1'b0;
        cmd_valid = 1'b0; cmd_rs = 1'b0; cmd_cs = 2'b00; cmd_data = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_lcd_rst_n", int'(lcd_rst_n), 0);
        chk("rst_lcd_pins", int'({lcd_e, lcd_rs, lcd_rw, lcd_cs1, lcd_cs2}), 0);
        chk("rst_lcd_data", int'(lcd_data), 0);
        chk("rst_fb", int'({fb_rd, fb_addr}), 0);
        chk("rst_cmd_ready_frame_done", int'({cmd_ready, frame_done}), 0);
        chk("rst_busy", int'(busy), 1);

        exp_q.push_back(wr(1'b0, 2'b11, 8'h3F));
        exp_q.push_back(wr(1'b0, 2'b11, 8'hC0));
        wr_cnt = 0;
        rst_n = 1'b1;
        check_powerup();
        wait_idle(2000);
        chk("init_write_count", wr_cnt, 2);
        chk("init_queue_empty", exp_q.size(), 0);

        // Frame A with a host command at the chip0/page0 boundary, then one coalesced frame B.
        push_frame(0, wr(1'b0, 2'b11, 8'h3E));
        push_frame(-1, 12'h000);
        w = wr_cnt;
        @(posedge clk); #1 refresh_req = 1'b1;
        @(posedge clk); #1 refresh_req = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!(fb_rd && fb_addr == 10'd10) && n < 5000);
        chk("reach_col10", int'(fb_addr), 10);
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_rs = 1'b0; cmd_cs = 2'b11; cmd_data = 8'h3E;
        n = 0;
        do begin @(negedge clk); n++; end while (!cmd_ready && n < 5000);
        chk("boundary_grant", int'(cmd_ready), 1);
        chk("grant_after_col63", int'(last_fetch), 63);
        @(posedge clk); #1 cmd_valid = 1'b0;
        repeat (3) begin
            repeat (40) @(posedge clk);
            #1 refresh_req = 1'b1;
            @(posedge clk); #1 refresh_req = 1'b0;
        end
        n = 0;
        while (fd_cnt < 2 && n < 100000) begin @(negedge clk); n++; end
        chk("two_frames_done", fd_cnt, 2);
        wait_idle(100);
        chk("frame_write_count", wr_cnt - w, 2 * 1056 + 1);
        chk("cmd_ready_one_cycle", rdy_cyc, 1);
        chk("frames_queue_empty", exp_q.size(), 0);
        w = wr_cnt;
        repeat (200) @(negedge clk);
        chk("stay_idle", int'(busy), 0);
        chk("no_extra_writes", wr_cnt, w);

        // Host and refresh requested together: host write first, then refresh; reset mid-data.
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_rs = 1'b1; cmd_cs = 2'b10; cmd_data = 8'h55; refresh_req = 1'b1;
        exp_q.push_back(wr(1'b1, 2'b10, 8'h55));
        exp_q.push_back(wr(1'b0, 2'b01, 8'hB8));
        exp_q.push_back(wr(1'b0, 2'b01, 8'h40));
        exp_q.push_back(wr(1'b1, 2'b01, 8'h00));
        @(negedge clk);
        chk("tie_host_ready", int'(cmd_ready), 1);
        @(posedge clk); #1 cmd_valid = 1'b0; refresh_req = 1'b0;
        n = 0;
        while (wr_cnt < w + 4 && n < 2000) begin @(negedge clk); n++; end
        chk("reach_first_data", wr_cnt, w + 4);
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk); #1;
        chk("abort_lcd_e", int'(lcd_e), 0);
        chk("abort_lcd_rst_n", int'(lcd_rst_n), 0);
        chk("abort_busy", int'(busy), 1);
        chk("abort_queue_empty", exp_q.size(), 0);
        repeat (2) @(posedge clk);
        #1;
        exp_q.push_back(wr(1'b0, 2'b11, 8'h3F));
        exp_q.push_back(wr(1'b0, 2'b11, 8'hC0));
        w = wr_cnt;
        rst_n = 1'b1;
        check_powerup();
        wait_idle(2000);
        chk("reinit_write_count", wr_cnt, w + 2);
        repeat (200) @(negedge clk);
        chk("no_refresh_after_abort", int'(busy), 0);
        chk("no_frame_done_on_abort", fd_cnt, 2);
        chk("final_queue_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
